// File: rtl/chipper_ingress_sched.sv
// Ingress scheduler for the chipper deflection router: round-robin loads four
// direction streams onto one load bus, idle-fills stragglers, then advances the router.
module chipper_ingress_sched #(
    parameter int             DW        = 7,
    parameter int             MAX_WAIT  = 8,
    parameter logic [DW-1:0]  IDLE_FLIT = {DW{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req_valid,
    input  logic [4*DW-1:0]   req_data,
    output logic [3:0]        req_ready,
    input  logic              cachemiss,
    output logic [DW-1:0]     inc,
    output logic              nsig,
    output logic              ssig,
    output logic              esig,
    output logic              wsig,
    output logic              clksig,
    output logic              busy
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FILL    = 2'd1,
        FIRE    = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [3:0]    loaded_r, loaded_s;
    logic [1:0]    rr_r, rr_s;
    logic [WW-1:0] wcnt_r, wcnt_s;
    logic [DW-1:0] inc_r, inc_s;
    logic [3:0]    strb_r, strb_s;
    logic          clk_r, clk_s;

    logic [3:0]    eligible_s;
    logic [7:0]    dbl_s;
    logic [3:0]    rot_s;
    logic [1:0]    grant_idx_s;
    logic          grant_vld_s;
    logic [3:0]    grant_s;
    logic [1:0]    fill_idx_s;

    // Index of the lowest set bit; 0 when none is set (callers qualify with |v).
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Round-robin grant: rotate the eligible set so rr lands at bit 0, pick lowest.
    always_comb begin
        eligible_s  = req_valid & ~loaded_r;
        dbl_s       = {eligible_s, eligible_s} >> rr_r;
        rot_s       = dbl_s[3:0];
        grant_idx_s = rr_r + lowest_set(rot_s);
        grant_s     = 4'b0000;
        grant_vld_s = 1'b0;
        // A saturated wait counter means this cycle hands over to idle filling.
        if ((state_r == COLLECT) && !cachemiss && !rst && (wcnt_r != WMAX) && (rot_s != 4'b0000)) begin
            grant_vld_s = 1'b1;
            grant_s     = 4'b0001 << grant_idx_s;
        end else begin
            grant_vld_s = 1'b0;
        end
    end

    assign fill_idx_s = lowest_set(~loaded_r);

    // Next-state and next-output logic for the epoch FSM.
    always_comb begin
        state_s  = state_r;
        loaded_s = loaded_r;
        rr_s     = rr_r;
        wcnt_s   = wcnt_r;
        inc_s    = inc_r;
        strb_s   = 4'b0000;
        clk_s    = 1'b0;
        case (state_r)
            COLLECT: begin
                if (cachemiss) begin
                    state_s = COLLECT;
                end else if (loaded_r == 4'b1111) begin
                    state_s = FIRE;
                    clk_s   = 1'b1;
                end else if ((loaded_r != 4'b0000) && (wcnt_r == WMAX)) begin
                    state_s = FILL;
                end else begin
                    if (grant_vld_s) begin
                        loaded_s = loaded_r | grant_s;
                        rr_s     = grant_idx_s + 2'd1;
                        inc_s    = req_data[int'(grant_idx_s)*DW +: DW];
                        strb_s   = grant_s;
                    end else begin
                        loaded_s = loaded_r;
                    end
                    if (loaded_r != 4'b0000) begin
                        wcnt_s = wcnt_r + WW'(1);
                    end else begin
                        wcnt_s = {WW{1'b0}};
                    end
                end
            end
            FILL: begin
                if (cachemiss) begin
                    state_s = FILL;
                end else if (loaded_r == 4'b1111) begin
                    state_s = FIRE;
                    clk_s   = 1'b1;
                end else begin
                    loaded_s = loaded_r | (4'b0001 << fill_idx_s);
                    inc_s    = IDLE_FLIT;
                    strb_s   = 4'b0001 << fill_idx_s;
                end
            end
            FIRE: begin
                if (cachemiss) begin
                    state_s = FIRE;
                end else begin
                    loaded_s = 4'b0000;
                    wcnt_s   = {WW{1'b0}};
                    state_s  = SETTLE;
                end
            end
            SETTLE: begin
                state_s = COLLECT;
            end
            default: begin
                state_s = COLLECT;
            end
        endcase
    end

    // State and registered outputs; reset abandons any epoch in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= COLLECT;
            loaded_r <= 4'b0000;
            rr_r     <= 2'd0;
            wcnt_r   <= {WW{1'b0}};
            inc_r    <= {DW{1'b0}};
            strb_r   <= 4'b0000;
            clk_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            loaded_r <= loaded_s;
            rr_r     <= rr_s;
            wcnt_r   <= wcnt_s;
            inc_r    <= inc_s;
            strb_r   <= strb_s;
            clk_r    <= clk_s;
        end
    end

    assign req_ready = grant_s;
    assign inc       = inc_r;
    assign nsig      = strb_r[0];
    assign ssig      = strb_r[1];
    assign esig      = strb_r[2];
    assign wsig      = strb_r[3];
    assign clksig    = clk_r;
    assign busy      = (state_r != COLLECT) || (loaded_r != 4'b0000);

endmodule

// File: doc/chipper_ingress_sched.md
# chipper_ingress_sched

Ingress scheduler for the chipper deflection router. It arbitrates four direction request streams (N, S, E, W) onto the router's single shared 7-bit load bus `inc` and pulses the matching port strobe for each flit. Once every input port has been loaded for the current router cycle, it issues the one-cycle `clksig` advance pulse. Ports with no traffic after a bounded wait are filled with an idle flit, so the router always advances with four defined inputs.

## Interface
- `DW`, 7, flit width on the load bus
- `MAX_WAIT`, 8, cycles allowed after the first grant of an epoch before unloaded ports are filled (≥1)
- `IDLE_FLIT`, 7'b0000000, value loaded into ports with no traffic

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  4  per-direction flit valid; bit0 N, bit1 S, bit2 E, bit3 W
- `req_data`  in  4*DW  per-direction flit; slice [i*DW +: DW] belongs to bit i
- `req_ready`  out  1x4  per-direction accept; a transfer occurs on valid&ready
- `cachemiss`  in  1  router stall; pauses scheduling while high
- `inc`  out  DW  registered load bus to router
- `nsig`, `ssig`, `esig`, `wsig`  out  1 each  registered port load strobes
- `clksig`  out  1  registered router advance pulse
- `busy`  out  1  high whenever the state is not COLLECT or the loaded mask is nonzero

## Operation
- Epoch: the interval between two `clksig` pulses. Each direction is loaded exactly once per epoch.
- State: `loaded[3:0]` mask, 2-bit round-robin pointer `rr`, wait counter `wcnt` (width ≥ clog2(MAX_WAIT+1)), and FSM.
- FSM states:
  - COLLECT → FIRE when `loaded` becomes 4'b1111.
  - COLLECT → FILL when `loaded`≠0 and `wcnt`==MAX_WAIT.
  - FILL → FIRE after the last unloaded port is filled.
  - FIRE → SETTLE after 1 cycle.
  - SETTLE → COLLECT after 1 cycle.
- COLLECT grant:
  - Eligible set = `req_valid & ~loaded`. Grant the first eligible index at or after `rr`, wrapping 3→0.
  - At most one grant per cycle. `req_ready` is high for the granted bit only; it is combinational from valid, mask, `rr` and state.
  - On grant: set the `loaded` bit, set `rr` = granted index + 1 mod 4, register `inc` = that slice, and register the matching strobe.
- `wcnt`: holds 0 while `loaded`==0; otherwise increments each COLLECT cycle, saturating at MAX_WAIT.
- FILL: one cycle per unloaded port in ascending index order. Each cycle drives `inc`=IDLE_FLIT plus that port's strobe and sets its mask bit. `req_ready`=0 throughout.
- FIRE: `clksig` is high for exactly one cycle. `loaded` and `wcnt` clear. `rr` is unchanged.
- SETTLE: one dead cycle with no strobes and `req_ready`=0. This gives the router one cycle to update its outputs.
- `cachemiss` high:
  - COLLECT: no grant, `req_ready`=0, `wcnt` frozen.
  - FILL and FIRE: the state and fill position hold, and no strobe or `clksig` is issued.
  - SETTLE: completes normally.
  - Resumes on the first cycle `cachemiss` is low.
- Simultaneous request on all four ports: served one per cycle in rotated order starting at `rr`.

## Timing
- Reset: `inc`=0, all strobes=0, `clksig`=0, `req_ready`=0, `busy`=0, `loaded`=0, `wcnt`=0, `rr`=0 (N), state=COLLECT.
- Reset mid-epoch (any state) abandons the epoch; no `clksig` is issued for it.
- Grant (handshake) in cycle t → strobe and `inc` valid in cycle t+1 only. Strobes are one cycle wide and at most one is high per cycle.
- When inactive, `inc` holds its last value.
- `clksig` rises in the cycle after the final strobe of the epoch. It never overlaps a strobe.
- Full epoch, four back-to-back grants at t..t+3:
  - strobes at t+1..t+4
  - `clksig` at t+5
  - SETTLE at t+6
  - next grant possible at t+7
- Fill timing: last grant at MAX_WAIT cycles after the first grant, then one strobe per missing port, then `clksig`.

## Test plan
- All valid after reset; N=7'h05, S=7'h61, E=7'h24, W=7'h64, with the first grant at cycle c.
  - Required: `inc` sequence 05,61,24,64 with nsig,ssig,esig,wsig on cycles c+1..c+4, `clksig` on c+5, `rr`=0 afterwards.
- Only N valid (7'h3C), MAX_WAIT=8.
  - Required: nsig with 3C; 8 cycles later ssig, esig, wsig each with `inc`=00, then one `clksig`; `req_ready` stays 0 during FILL.
- Rotation across epochs.
  - Epoch 1: only E valid; W then presented late enough to be filled.
  - Epoch 2: all four valid.
  - Required order in epoch 2: W, N, S, E.
- `cachemiss` held high 5 cycles after two grants in COLLECT.
  - Required: no `req_ready`, strobe or `clksig` during those cycles, `wcnt` unchanged.
  - Required after release: remaining two grants, then `clksig` with the normal spacing.
- `rst` asserted during FILL after one idle fill strobe.
  - Required: next cycle all outputs 0, `loaded`=0, no `clksig`.
  - Required: a subsequent full four-port epoch behaves exactly as in scenario 1.
- `req_valid` held high on N for two epochs.
  - Required: N accepted at most once per epoch; the second N flit waits until after SETTLE.
